mem_datos_bytes: RTL and testbench
==================================

# mem_datos_bytes

Parametrised single-port data memory for the processor datapath: byte, half-word and word loads/stores with little-endian byte lanes, sign/zero extension on loads, misalignment detection, a registered read port with a valid strobe, and a hardware clear sequencer that zeroes the whole array after reset. It sits between the ALU address output and the write-back mux and supersedes the fixed 32-word word-only data memory.

## Interface
- `ADDR_W`, default 7: byte-address width; word depth `DEPTH = 2**(ADDR_W-2)`, so the default is 32 words.
- `INIT_CLEAR`, default 1: 1 runs the post-reset clear sequencer; 0 skips it. With 0, `busy` falls on the first edge with `rst` low and array contents are unspecified.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  1: access request, sampled on the rising edge.
- `we`  in  1: 1 = store, 0 = load; qualified by `req`.
- `size`  in  2: 00 byte, 01 half, 10 word, 11 illegal.
- `unsigned_ld`  in  1: 1 zero-extends byte/half loads; 0 sign-extends them.
- `addr`  in  ADDR_W: byte address.
- `wdata`  in  32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rdata`  out  32: load result, extended to 32 bits.
- `rvalid`  out  1: one-cycle pulse; `rdata` is valid.
- `misalign`  out  1: one-cycle pulse; the access was rejected.
- `busy`  out  1: high while resetting or clearing; requests are ignored.

## Operation
- States: CLEAR and RUN. `rst` forces CLEAR from any state.
- Reset edge (`rst`=1): state←CLEAR, clear pointer←0, busy←1, rdata←0, rvalid←0, misalign←0. Any in-flight request is discarded and the array is not written.
- CLEAR, each edge with `rst`=0: mem[ptr]←0 and ptr←ptr+1. On the edge that writes word DEPTH-1, state←RUN and busy←0.
- RUN: a request is accepted on an edge with `req`=1, `busy`=0 and `rst`=0. There is at most one access per cycle.
- Word index is addr[ADDR_W-1:2] and lane is addr[1:0]. The address space exactly covers DEPTH, so no out-of-range case exists.
- Misaligned (rejected) accesses:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - any access with size=11.
- A rejected access does not write the array, leaves `rdata` unchanged and pulses `misalign` only. `rvalid` stays 0, even for loads.
- Stores write the selected lanes only:
  - SB writes wdata[7:0] to lane addr[1:0];
  - SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1};
  - SW writes all four lanes.
- Loads extract the byte at lane addr[1:0], or the half at lanes {addr[1],0..1} (low byte at the lower address), or the full word. Sign or zero extension is per `unsigned_ld`; word loads ignore `unsigned_ld`.
- `rdata` holds the last load result until the next accepted load or reset.

## Timing
- Store accepted at edge k: array updated at edge k. A load of the same address accepted at edge k+1 returns the new data.
- Load accepted at edge k: rdata is updated and rvalid=1 from edge k, for exactly one cycle. Loads accepted on back-to-back edges produce back-to-back rvalid pulses.
- misalign: asserted on the edge the rejected request is sampled; lasts one cycle.
- A store never asserts rvalid.
- Clear duration: busy stays high for exactly DEPTH edges after `rst` deasserts (32 with the defaults). It is first low on the edge where the first request can be accepted.
- `rst` asserted mid-clear: the pointer returns to 0 and the full clear restarts.
- `req` high while busy: ignored, with no pulses and no write.
- Reset values: rdata=0, rvalid=0, misalign=0, busy=1.

## Test plan
- Clear: assert rst 2 cycles, release, count edges → busy falls after 32 edges. Then LW of every word address 0,4,…,124 → rdata=0, rvalid pulses each cycle.
- Word stream: SW 0xAABBCCD0+i to addr 4i for i=0..31 on consecutive cycles, then LW all → rdata=0xAABBCCD0+i for each i.
- Byte/half merge on word 8:
  - SW 0x11223344; SB 0xEE to addr 9; SH 0x8001 to addr 10.
  - LW 8 → 0x8001EE44.
  - LB 9 signed → 0xFFFFFFEE; LB 9 unsigned → 0x000000EE.
  - LH 10 signed → 0xFFFF8001; LH 10 unsigned → 0x00008001.
- Misalignment:
  - SW 0xDEADBEEF to addr 6 and SH to addr 5 → misalign pulse, no rvalid, word 4 unchanged.
  - size=11 load → misalign pulse, rdata unchanged.
- Busy/reset interaction:
  - req asserted during clear → no rvalid or misalign pulses, and no write.
  - Re-assert rst at clear pointer 10 → busy stays high for a fresh 32 edges.
  - Reset asserted together with a load → rvalid stays 0 and rdata=0.
- Read-after-write: SW 0x0000CAFE to addr 20 at edge k, LW 20 at edge k+1 → rdata=0x0000CAFE with rvalid at edge k+1.

Source files
------------

// File: rtl/mem_datos_bytes_if.sv
// Request/response bundle for the byte-addressable data memory.
// The master drives an access; the slave returns load data and status strobes.
interface mem_datos_bytes_if #(
    parameter int ADDR_W = 7
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              misalign;
    logic              busy;

    modport master (
        output req, we, size, unsigned_ld, addr, wdata,
        input  rdata, rvalid, misalign, busy
    );

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata,
        output rdata, rvalid, misalign, busy
    );
endinterface

// File: rtl/mem_datos_bytes.sv
// Single-port data memory with byte/half/word little-endian access, load
// extension, misalignment rejection, registered read port and post-reset clear.
module mem_datos_bytes #(
    parameter int ADDR_W     = 7,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    mem_datos_bytes_if.slave bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int PW    = ADDR_W - 2;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            clr_we;
    logic            acc;
    logic            bad;
    logic            st;
    logic            ld;
    logic [PW-1:0]   widx;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic [31:0]     word;
    logic [7:0]      b;
    logic [15:0]     h;
    logic [31:0]     ld_val;
    logic [31:0]     mem [DEPTH];

    assign widx     = bus.addr[ADDR_W-1:2];
    assign lane     = bus.addr[1:0];
    assign bus.busy = (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        acc     = 1'b0;
        case (state_q)
            CLEAR: begin
                if (INIT_CLEAR) begin
                    clr_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (ptr_q == PW'(DEPTH - 1)) state_d = RUN;
                end else begin
                    state_d = RUN;
                end
            end
            RUN:     acc = bus.req;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        bad = 1'b0;
        case (bus.size)
            2'b01:   bad = bus.addr[0];
            2'b10:   bad = (lane != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
        st = acc && !bad && bus.we;
        ld = acc && !bad && !bus.we;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be = 4'b0000;
        wd = bus.wdata;
        case (bus.size)
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{bus.wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[ptr_q] <= '0;
            end else if (st) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (be[k]) mem[widx][8*k +: 8] <= wd[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        word   = mem[widx];
        b      = word[8*lane +: 8];
        h      = lane[1] ? word[31:16] : word[15:0];
        ld_val = word;
        case (bus.size)
            2'b00:   ld_val = bus.unsigned_ld ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   ld_val = bus.unsigned_ld ? {16'b0, h} : {{16{h[15]}}, h};
            default: ld_val = word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rdata    <= '0;
            bus.rvalid   <= 1'b0;
            bus.misalign <= 1'b0;
        end else begin
            bus.rvalid   <= ld;
            bus.misalign <= acc && bad;
            if (ld) bus.rdata <= ld_val;
        end
    end
endmodule

// File: tb/tb_mem_datos_bytes.sv
// Directed, table-driven self-checking bench for mem_datos_bytes.
module tb_mem_datos_bytes;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_datos_bytes_if #(.ADDR_W(7)) bus ();

    mem_datos_bytes #(.ADDR_W(7), .INIT_CLEAR(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_rvalid;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [6:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.req = 1'b1; bus.we = we; bus.size = size;
        bus.unsigned_ld = uns; bus.addr = addr; bus.wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    // Releases rst and counts edges until busy drops (bounded by max_edges).
    task automatic run_clear(input int max_edges, input bit with_req,
                             output int n, output int pulses);
        bit done = 1'b0;
        n = 0;
        pulses = 0;
        for (int i = 0; i < max_edges && !done; i++) begin
            @(negedge clk);
            rst = 1'b0;
            bus.req = with_req;
            bus.we = (i % 2 == 0);
            bus.size = (i % 2 == 0) ? 2'b10 : 2'b11;
            bus.addr = '0;
            bus.wdata = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            n++;
            if (bus.rvalid || bus.misalign) pulses++;
            if (!bus.busy) done = 1'b1;
        end
        bus.req = 1'b0;
    endtask

    initial begin
        int n, pulses;
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b10;
        bus.unsigned_ld = 1'b0; bus.addr = '0; bus.wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",     32'(bus.busy),     32'd1);
        chk("reset_rdata",    bus.rdata,         32'h0);
        chk("reset_rvalid",   32'(bus.rvalid),   32'd0);
        chk("reset_misalign", 32'(bus.misalign), 32'd0);

        run_clear(100, 1'b1, n, pulses);
        chk("clear_edges",  32'(n),      32'd32);
        chk("clear_pulses", 32'(pulses), 32'd0);

        for (int i = 0; i < 32; i++) begin
            do_op(1'b0, 2'b10, 1'b0, 7'(4 * i), '0);
            chk($sformatf("clr_lw%0d", i), bus.rdata, 32'h0);
            chk($sformatf("clr_rv%0d", i), 32'(bus.rvalid), 32'd1);
        end

        for (int i = 0; i < 32; i++) begin
            do_op(1'b1, 2'b10, 1'b0, 7'(4 * i), 32'hAABB_CCD0 + 32'(i));
            chk($sformatf("sw_rv%0d", i), 32'(bus.rvalid), 32'd0);
        end
        for (int i = 0; i < 32; i++) begin
            do_op(1'b0, 2'b10, 1'b0, 7'(4 * i), '0);
            chk($sformatf("lw%0d", i), bus.rdata, 32'hAABB_CCD0 + 32'(i));
            chk($sformatf("lw_rv%0d", i), 32'(bus.rvalid), 32'd1);
        end

        // name, we, size, uns, addr, wdata, exp_rdata, exp_rvalid, exp_mis
        vecs.push_back('{"sw8",      1'b1, 2'b10, 1'b0, 7'd8,  32'h1122_3344, 32'hAABB_CCEF, 1'b0, 1'b0});
        vecs.push_back('{"sb9",      1'b1, 2'b00, 1'b0, 7'd9,  32'h0000_00EE, 32'hAABB_CCEF, 1'b0, 1'b0});
        vecs.push_back('{"sh10",     1'b1, 2'b01, 1'b0, 7'd10, 32'h0000_8001, 32'hAABB_CCEF, 1'b0, 1'b0});
        vecs.push_back('{"lw8",      1'b0, 2'b10, 1'b0, 7'd8,  32'h0,         32'h8001_EE44, 1'b1, 1'b0});
        vecs.push_back('{"lb9s",     1'b0, 2'b00, 1'b0, 7'd9,  32'h0,         32'hFFFF_FFEE, 1'b1, 1'b0});
        vecs.push_back('{"lb9u",     1'b0, 2'b00, 1'b1, 7'd9,  32'h0,         32'h0000_00EE, 1'b1, 1'b0});
        vecs.push_back('{"lh10s",    1'b0, 2'b01, 1'b0, 7'd10, 32'h0,         32'hFFFF_8001, 1'b1, 1'b0});
        vecs.push_back('{"lh10u",    1'b0, 2'b01, 1'b1, 7'd10, 32'h0,         32'h0000_8001, 1'b1, 1'b0});
        vecs.push_back('{"lb11s",    1'b0, 2'b00, 1'b0, 7'd11, 32'h0,         32'hFFFF_FF80, 1'b1, 1'b0});
        vecs.push_back('{"lh8u",     1'b0, 2'b01, 1'b1, 7'd8,  32'h0,         32'h0000_EE44, 1'b1, 1'b0});
        vecs.push_back('{"lw8_uns",  1'b0, 2'b10, 1'b1, 7'd8,  32'h0,         32'h8001_EE44, 1'b1, 1'b0});
        vecs.push_back('{"sw6_mis",  1'b1, 2'b10, 1'b0, 7'd6,  32'hDEAD_BEEF, 32'h8001_EE44, 1'b0, 1'b1});
        vecs.push_back('{"sh5_mis",  1'b1, 2'b01, 1'b0, 7'd5,  32'h0000_1234, 32'h8001_EE44, 1'b0, 1'b1});
        vecs.push_back('{"lw4",      1'b0, 2'b10, 1'b0, 7'd4,  32'h0,         32'hAABB_CCD1, 1'b1, 1'b0});
        vecs.push_back('{"sz11_mis", 1'b0, 2'b11, 1'b0, 7'd0,  32'h0,         32'hAABB_CCD1, 1'b0, 1'b1});
        vecs.push_back('{"lw2_mis",  1'b0, 2'b10, 1'b0, 7'd2,  32'h0,         32'hAABB_CCD1, 1'b0, 1'b1});
        vecs.push_back('{"lh7_mis",  1'b0, 2'b01, 1'b0, 7'd7,  32'h0,         32'hAABB_CCD1, 1'b0, 1'b1});
        vecs.push_back('{"lw4_again",1'b0, 2'b10, 1'b0, 7'd4,  32'h0,         32'hAABB_CCD1, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            do_op(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            chk({vecs[i].name, "_rdata"},  bus.rdata,           vecs[i].exp_rdata);
            chk({vecs[i].name, "_rvalid"}, 32'(bus.rvalid),     32'(vecs[i].exp_rvalid));
            chk({vecs[i].name, "_mis"},    32'(bus.misalign),   32'(vecs[i].exp_mis));
        end
        idle();
        @(posedge clk);
        #1;
        chk("idle_rvalid",   32'(bus.rvalid),   32'd0);
        chk("idle_misalign", 32'(bus.misalign), 32'd0);

        do_op(1'b1, 2'b10, 1'b0, 7'd20, 32'h0000_CAFE);
        do_op(1'b0, 2'b10, 1'b0, 7'd20, '0);
        chk("raw_rdata",  bus.rdata,       32'h0000_CAFE);
        chk("raw_rvalid", 32'(bus.rvalid), 32'd1);
        idle();

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_clear(10, 1'b0, n, pulses);
        chk("midclear_edges", 32'(n), 32'd10);
        chk("midclear_busy",  32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rerst_busy", 32'(bus.busy), 32'd1);
        run_clear(100, 1'b0, n, pulses);
        chk("restart_edges", 32'(n), 32'd32);

        do_op(1'b0, 2'b10, 1'b0, 7'd20, '0);
        chk("recleared_w20", bus.rdata, 32'h0);
        do_op(1'b1, 2'b10, 1'b0, 7'd20, 32'h0000_0055);
        do_op(1'b0, 2'b10, 1'b0, 7'd20, '0);
        chk("pre_rst_load", bus.rdata, 32'h0000_0055);

        @(negedge clk);
        rst = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.addr = 7'd20;
        @(posedge clk);
        #1;
        chk("rstld_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rstld_rdata",  bus.rdata,       32'h0);
        chk("rstld_busy",   32'(bus.busy),   32'd1);
        @(negedge clk);
        bus.req = 1'b0;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
